bank_sc_xbar_tx: RTL and testbench

Bank-side transmitter for the bank-to-crossbar read-return interface (bankN_sc_xbar_*). One instance sits at each cache bank, between the bank's read pipeline and the crossbar's per-channel reorder buffers. It accepts completed read beats tagged with channel id and ROB number, and buffers them in a small FIFO. It then drives them onto the sc_xbar valid/allowIn handshake in arrival order, so pipeline stalls are decoupled from crossbar back-pressure. Illegal channel ids are dropped and flagged.

---
 rtl/bank_sc_xbar_tx_pkg.sv | 23 ++
 rtl/bank_sc_xbar_tx_if.sv | 19 +
 rtl/bank_sc_xbar_tx_fifo.sv | 61 ++++++
 rtl/bank_sc_xbar_tx.sv | 75 +++++++
 tb/tb_bank_sc_xbar_tx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_sc_xbar_tx_pkg.sv
// Shared types and constants for the bank <-> crossbar read-return path.
package xbar_pkg;

    localparam int CH_ID_W   = 2;
    localparam int ROB_NUM_W = 3;
    localparam int DATA_W    = 128;
    localparam int NUM_CH    = 3;

    localparam logic [CH_ID_W-1:0] CH_ID_ILLEGAL = 2'd3;

    // One read-return beat as it travels from bank to crossbar.
    typedef struct packed {
        logic [CH_ID_W-1:0]   ch_id;
        logic [ROB_NUM_W-1:0] rob_num;
        logic [DATA_W-1:0]    data;
    } rtn_beat_t;

    // A channel id names a real crossbar channel only below NUM_CH.
    function automatic logic is_legal_ch(input logic [CH_ID_W-1:0] ch);
        return (ch != CH_ID_ILLEGAL) && (int'(ch) < NUM_CH);
    endfunction

endpackage

// File: rtl/bank_sc_xbar_tx_if.sv
// Read-return beat channel with a valid/allowIn handshake.
//
// Handshake: the master drives valid plus payload; the slave drives allowIn.
// A beat transfers on a rising clock edge where valid and allowIn are both 1.
// While valid is high and allowIn low, the master holds the payload stable.
// allowIn may be asserted independently of valid.
interface bank_sc_xbar_tx_if;
    import xbar_pkg::*;

    logic                 valid;
    logic                 allowIn;
    logic [CH_ID_W-1:0]   ch_id;
    logic [ROB_NUM_W-1:0] rob_num;
    logic [DATA_W-1:0]    data;

    modport master (output valid, output ch_id, output rob_num, output data, input allowIn);
    modport slave  (input valid, input ch_id, input rob_num, input data, output allowIn);

endinterface

// File: rtl/bank_sc_xbar_tx_fifo.sv
// Generic synchronous FIFO of rtn_beat_t with occupancy count.
// Full/empty come from the count, so pointers simply wrap modulo DEPTH.
// The caller must not push when full or pop when empty.
module xbar_sync_fifo
    import xbar_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  rtn_beat_t   i_push_data,
    input  logic        i_pop,
    output rtn_beat_t   o_head,
    output logic [PTR_W:0] o_count
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    rtn_beat_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    // Entry storage is deliberately left unreset; only valid entries are read.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Write/read pointers advance modulo DEPTH on push/pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_ONE;
            if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/bank_sc_xbar_tx.sv
// Bank-side read-return transmitter: buffers pipeline beats in a small FIFO
// and replays them to the crossbar in arrival order. Beats addressed to an
// illegal channel are handshaken but dropped, raising a sticky error flag.
module bank_sc_xbar_tx
    import xbar_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    bank_sc_xbar_tx_if.slave         pipe_rtn,
    bank_sc_xbar_tx_if.master        bank_sc_xbar,
    output logic [PTR_W:0]           fifo_cnt_o,
    output logic                     err_illegal_ch_o,
    input  logic                     err_clr_i
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W:0] w_count;
    logic           w_allow_in;
    logic           w_accept;
    logic           w_legal;
    logic           w_push;
    logic           w_drop;
    logic           w_valid;
    logic           w_pop;
    rtn_beat_t      w_push_beat;
    rtn_beat_t      w_head;
    logic           r_err;

    // allowIn depends only on registered occupancy: a pop in the same cycle
    // does not reopen a full FIFO, which keeps crossbar allowIn off this path.
    assign w_allow_in = (w_count != FULL_CNT);
    assign w_accept   = pipe_rtn.valid & w_allow_in;
    assign w_legal    = is_legal_ch(pipe_rtn.ch_id);
    assign w_push     = w_accept & w_legal;
    assign w_drop     = w_accept & ~w_legal;

    assign w_valid    = (w_count != '0);
    assign w_pop      = w_valid & bank_sc_xbar.allowIn;

    assign w_push_beat = '{ch_id: pipe_rtn.ch_id, rob_num: pipe_rtn.rob_num, data: pipe_rtn.data};

    xbar_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_push      (w_push),
        .i_push_data (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // Sticky illegal-channel flag; a new drop beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end

    assign pipe_rtn.allowIn       = w_allow_in;
    assign bank_sc_xbar.valid     = w_valid;
    assign bank_sc_xbar.ch_id     = w_head.ch_id;
    assign bank_sc_xbar.rob_num   = w_head.rob_num;
    assign bank_sc_xbar.data      = w_head.data;
    assign fifo_cnt_o             = w_count;
    assign err_illegal_ch_o       = r_err;

endmodule

// File: tb/tb_bank_sc_xbar_tx.sv
// Self-checking bench for bank_sc_xbar_tx: a queue-based reference model
// predicts occupancy, handshake and error state; a monitor compares the
// DUT against it every cycle and pops expected beats as they leave.
module tb_bank_sc_xbar_tx;
    import xbar_pkg::*;

    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BEAT_W = $bits(rtn_beat_t);

    logic           clk_i;
    logic           rst_i;
    logic [PTR_W:0] fifo_cnt_o;
    logic           err_illegal_ch_o;
    logic           err_clr_i;

    bank_sc_xbar_tx_if pipe_if ();
    bank_sc_xbar_tx_if xbar_if ();

    bank_sc_xbar_tx #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .pipe_rtn         (pipe_if),
        .bank_sc_xbar     (xbar_if),
        .fifo_cnt_o       (fifo_cnt_o),
        .err_illegal_ch_o (err_illegal_ch_o),
        .err_clr_i        (err_clr_i)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ---------------- scoreboard state ----------------
    logic [BEAT_W-1:0] exp_q[$];
    int  m_cnt;
    bit  m_err;
    int  n_vec;
    int  n_err;
    bit  rand_done;

    task automatic check(input string nm, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference model: a FIFO is an ordered list of legal beats, limited to
    // DEPTH entries, where acceptance is judged on the occupancy before the edge.
    task automatic model_step();
        bit acc;
        bit legal;
        bit pop;
        acc   = pipe_if.valid && (m_cnt < DEPTH);
        legal = (pipe_if.ch_id != 2'd3);
        pop   = (m_cnt > 0) && xbar_if.allowIn;
        if (acc && legal) exp_q.push_back({pipe_if.ch_id, pipe_if.rob_num, pipe_if.data});
        m_cnt <= m_cnt + ((acc && legal) ? 1 : 0) - (pop ? 1 : 0);
        if (acc && !legal) m_err <= 1'b1;
        else if (err_clr_i) m_err <= 1'b0;
    endtask

    always @(posedge clk_i) begin
        if (!rst_i) begin
            exp_q.delete();
            m_cnt <= 0;
            m_err <= 1'b0;
        end else begin
            model_step();
        end
    end

    // Monitor: compare DUT state to the model away from the active edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            check("fifo_cnt", BEAT_W'(fifo_cnt_o), BEAT_W'(m_cnt));
            check("allowIn_o", BEAT_W'(pipe_if.allowIn), BEAT_W'(m_cnt < DEPTH));
            check("valid_o", BEAT_W'(xbar_if.valid), BEAT_W'(m_cnt != 0));
            check("err", BEAT_W'(err_illegal_ch_o), BEAT_W'(m_err));
            if (xbar_if.valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_beat");
                end else begin
                    check("head_beat", {xbar_if.ch_id, xbar_if.rob_num, xbar_if.data}, exp_q[0]);
                    if (xbar_if.allowIn) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a beat and hold it until the DUT accepts it; returns just after
    // the accepting edge so another beat can follow back-to-back.
    task automatic send(input logic [1:0] ch, input logic [2:0] rob, input logic [DATA_W-1:0] d);
        bit got;
        got = 1'b0;
        pipe_if.valid   = 1'b1;
        pipe_if.ch_id   = ch;
        pipe_if.rob_num = rob;
        pipe_if.data    = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (pipe_if.allowIn) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("send_timeout");
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        pipe_if.valid = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        xbar_if.allowIn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!xbar_if.valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail("drain_timeout");
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i           = 1'b0;
        err_clr_i       = 1'b0;
        pipe_if.valid   = 1'b0;
        pipe_if.ch_id   = '0;
        pipe_if.rob_num = '0;
        pipe_if.data    = '0;
        xbar_if.allowIn = 1'b0;
        n_vec = 0;
        n_err = 0;
        m_cnt = 0;
        m_err = 1'b0;
        rand_done = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Reset then idle
        @(negedge clk_i);
        check("rst_valid", BEAT_W'(xbar_if.valid), '0);
        check("rst_allowIn", BEAT_W'(pipe_if.allowIn), BEAT_W'(1));
        check("rst_cnt", BEAT_W'(fifo_cnt_o), '0);
        check("rst_err", BEAT_W'(err_illegal_ch_o), '0);
        @(posedge clk_i);
        #1;

        // Single beat straight through
        xbar_if.allowIn = 1'b1;
        send(2'd1, 3'd5, {16{8'hA5}});
        idle(3);

        // Fill to full with crossbar stalled; fifth beat waits
        xbar_if.allowIn = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd0, 3'(i), rand_data());
        fork
            send(2'd0, 3'd4, rand_data());
            begin
                repeat (4) @(posedge clk_i);
                #1 xbar_if.allowIn = 1'b1;
            end
        join
        idle(1);
        drain();

        // Steady push+pop at occupancy 2 across pointer wrap
        xbar_if.allowIn = 1'b0;
        send(2'd2, 3'd1, rand_data());
        send(2'd1, 3'd2, rand_data());
        xbar_if.allowIn = 1'b1;
        for (int i = 0; i < 16; i++) send(2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), rand_data());
        idle(1);
        drain();

        // Illegal channel: dropped, flag set; clear vs new drop; lone clear
        send(2'd3, 3'd6, rand_data());
        idle(2);
        err_clr_i = 1'b1;
        send(2'd3, 3'd2, rand_data());
        err_clr_i = 1'b0;
        idle(2);
        err_clr_i = 1'b1;
        idle(1);
        err_clr_i = 1'b0;
        idle(2);

        // Randomised traffic with random back-pressure and error clears
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                         3'($urandom_range(0, 7)), rand_data());
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    xbar_if.allowIn = ($urandom_range(0, 2) != 0);
                    err_clr_i       = ($urandom_range(0, 15) == 0);
                    @(posedge clk_i);
                    #1;
                end
                err_clr_i = 1'b0;
            end
        join
        idle(1);
        drain();

        // Asynchronous reset with buffered beats
        xbar_if.allowIn = 1'b0;
        for (int i = 0; i < 3; i++) send(2'd1, 3'(i), rand_data());
        idle(1);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        #1;
        check("async_rst_valid", BEAT_W'(xbar_if.valid), '0);
        check("async_rst_cnt", BEAT_W'(fifo_cnt_o), '0);
        check("async_rst_allowIn", BEAT_W'(pipe_if.allowIn), BEAT_W'(1));
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        xbar_if.allowIn = 1'b1;
        send(2'd0, 3'd7, rand_data());
        idle(1);
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound in case a handshake never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
